// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register with a configurable number of stages.
// Each stage holds {valid, reg_write, mem_to_reg, alu, mem, rd}. The pipe
// supports stall (hold every stage) and flush (load a bubble into stage 0).
// It also exposes per-stage forwarding taps and counts output bubbles.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   stall, flush          hazard-unit controls
//   valid_in, wb, alu_data, mem_data, rd   MEM-stage inputs (wb[1]=reg_write, wb[0]=mem_to_reg)
//   valid_out, reg_write, mem_to_reg, alu_data_out, mem_data_out, rd_out
//                         last-stage fields
//   wb_data               last-stage selected write-back data
//   fwd_we/fwd_rd/fwd_data  per-stage taps; bit/slice k = stage k
//   bubble_cnt            saturating count of cycles with valid_out == 0

// One pipeline stage. A bubble clears the stage and takes priority over load.
module mem_wb_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (bubble) q <= '0;
    else if (load)   q <= d;
  end
endmodule

module mem_wb_pipe #(
  parameter int DATA_W            = 32,
  parameter int REG_W             = 5,
  parameter int DEPTH             = 1,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic [1:0]              wb,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic [REG_W-1:0]        rd,
  output logic                    valid_out,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic [DATA_W-1:0]       alu_data_out,
  output logic [DATA_W-1:0]       mem_data_out,
  output logic [REG_W-1:0]        rd_out,
  output logic [DATA_W-1:0]       wb_data,
  output logic [DEPTH-1:0]        fwd_we,
  output logic [DEPTH*REG_W-1:0]  fwd_rd,
  output logic [DEPTH*DATA_W-1:0] fwd_data,
  output logic [15:0]             bubble_cnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("mem_wb_pipe: DEPTH must be in 1..4");
  end

  typedef struct packed {
    logic              vld;
    logic              we;
    logic              m2r;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [REG_W-1:0]  rd;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t              in_e;
  entry_t [DEPTH-1:0]  stg;
  logic                zr_hit;

  // Only qualified control is stored, so downstream never sees a raw
  // reg_write for an invalid slot or for the hardwired zero register.
  assign zr_hit     = (ZERO_REG_SUPPRESS != 0) && (rd == '0);
  assign in_e.vld   = valid_in;
  assign in_e.we    = wb[1] & valid_in & ~zr_hit;
  assign in_e.m2r   = wb[0] & valid_in;
  assign in_e.alu   = alu_data;
  assign in_e.mem   = mem_data;
  assign in_e.rd    = rd;

  // Flush only affects stage 0; later stages follow stall as usual.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    mem_wb_stage #(.W(EW)) u_stg (
      .clk    (clk),
      .rst    (rst),
      .load   (~stall),
      .bubble ((k == 0) ? flush : 1'b0),
      .d      ((k == 0) ? in_e : stg[(k == 0) ? 0 : k-1]),
      .q      (stg[k])
    );

    assign fwd_we[k]                       = stg[k].we;
    assign fwd_rd[k*REG_W +: REG_W]        = stg[k].rd;
    assign fwd_data[k*DATA_W +: DATA_W]    = stg[k].m2r ? stg[k].mem : stg[k].alu;
  end

  assign valid_out    = stg[DEPTH-1].vld;
  assign reg_write    = stg[DEPTH-1].we;
  assign mem_to_reg   = stg[DEPTH-1].m2r;
  assign alu_data_out = stg[DEPTH-1].alu;
  assign mem_data_out = stg[DEPTH-1].mem;
  assign rd_out       = stg[DEPTH-1].rd;
  assign wb_data      = fwd_data[(DEPTH-1)*DATA_W +: DATA_W];

  // Counts every non-reset edge that sees an empty output slot, stall or not.
  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (!valid_out && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [1:0]  wb = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [4:0]  rd = '0;

  always #5 clk = ~clk;

  // u1: DEPTH=1, zero suppress on
  logic        v1, we1, m2r1; logic [31:0] a1, m1, wbd1; logic [4:0] r1;
  logic [0:0]  fwe1; logic [4:0] frd1; logic [31:0] fd1; logic [15:0] bc1;
  // uz: DEPTH=1, zero suppress off
  logic        vz, wez, m2rz; logic [31:0] az, mz, wbdz; logic [4:0] rz;
  logic [0:0]  fwez; logic [4:0] frdz; logic [31:0] fdz; logic [15:0] bcz;
  // u2: DEPTH=2
  logic        v2, we2, m2r2; logic [31:0] a2, m2, wbd2; logic [4:0] r2;
  logic [1:0]  fwe2; logic [9:0] frd2; logic [63:0] fd2; logic [15:0] bc2;
  // u3: DEPTH=3
  logic        v3, we3, m2r3; logic [31:0] a3, m3, wbd3; logic [4:0] r3;
  logic [2:0]  fwe3; logic [14:0] frd3; logic [95:0] fd3; logic [15:0] bc3;

  mem_wb_pipe #(.DEPTH(1), .ZERO_REG_SUPPRESS(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .wb(wb),
    .alu_data(alu_data), .mem_data(mem_data), .rd(rd), .valid_out(v1), .reg_write(we1),
    .mem_to_reg(m2r1), .alu_data_out(a1), .mem_data_out(m1), .rd_out(r1), .wb_data(wbd1),
    .fwd_we(fwe1), .fwd_rd(frd1), .fwd_data(fd1), .bubble_cnt(bc1));
  mem_wb_pipe #(.DEPTH(1), .ZERO_REG_SUPPRESS(0)) uz (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .wb(wb),
    .alu_data(alu_data), .mem_data(mem_data), .rd(rd), .valid_out(vz), .reg_write(wez),
    .mem_to_reg(m2rz), .alu_data_out(az), .mem_data_out(mz), .rd_out(rz), .wb_data(wbdz),
    .fwd_we(fwez), .fwd_rd(frdz), .fwd_data(fdz), .bubble_cnt(bcz));
  mem_wb_pipe #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .wb(wb),
    .alu_data(alu_data), .mem_data(mem_data), .rd(rd), .valid_out(v2), .reg_write(we2),
    .mem_to_reg(m2r2), .alu_data_out(a2), .mem_data_out(m2), .rd_out(r2), .wb_data(wbd2),
    .fwd_we(fwe2), .fwd_rd(frd2), .fwd_data(fd2), .bubble_cnt(bc2));
  mem_wb_pipe #(.DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .wb(wb),
    .alu_data(alu_data), .mem_data(mem_data), .rd(rd), .valid_out(v3), .reg_write(we3),
    .mem_to_reg(m2r3), .alu_data_out(a3), .mem_data_out(m3), .rd_out(r3), .wb_data(wbd3),
    .fwd_we(fwe3), .fwd_rd(frd3), .fwd_data(fd3), .bubble_cnt(bc3));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic vi, input logic [1:0] w, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] m);
    valid_in = vi; wb = w; rd = r; alu_data = a; mem_data = m;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic vi; logic [1:0] wb; logic [4:0] rd; logic [31:0] alu, mem;
    logic e_v, e_we, e_m2r, e_wez; logic [31:0] e_wbd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 2'b11, 5'd7,  32'h1234, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 2'b10, 5'd7,  32'h1234, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234};
    tbl[2] = '{1'b1, 2'b10, 5'd0,  32'h55,   32'h66,       1'b1, 1'b0, 1'b0, 1'b1, 32'h55};
    tbl[3] = '{1'b0, 2'b11, 5'd3,  32'h77,   32'h88,       1'b0, 1'b0, 1'b0, 1'b0, 32'h77};
    tbl[4] = '{1'b1, 2'b01, 5'd31, 32'h9,    32'hABC,      1'b1, 1'b0, 1'b1, 1'b0, 32'hABC};
    tbl[5] = '{1'b1, 2'b00, 5'd1,  32'h42,   32'h43,       1'b1, 1'b0, 1'b0, 1'b0, 32'h42};

    // Reset state
    do_reset();
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_bubble", {16'd0, bc1}, 32'd0);
    chk("rst_fwd_we3", {29'd0, fwe3}, 32'd0);
    chk("rst_alu3", a3, 32'd0);

    // Single-stage vectors, one edge latency
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].vi, tbl[i].wb, tbl[i].rd, tbl[i].alu, tbl[i].mem);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, v1}, {31'd0, tbl[i].e_v});
      chk($sformatf("v%0d_we", i), {31'd0, we1}, {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_fwd_we", i), {31'd0, fwe1}, {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_m2r", i), {31'd0, m2r1}, {31'd0, tbl[i].e_m2r});
      chk($sformatf("v%0d_rd", i), {27'd0, r1}, {27'd0, tbl[i].rd});
      chk($sformatf("v%0d_wbdata", i), wbd1, tbl[i].e_wbd);
      chk($sformatf("v%0d_fwd_data", i), fd1, tbl[i].e_wbd);
      chk($sformatf("v%0d_we_nozr", i), {31'd0, wez}, {31'd0, tbl[i].e_wez});
    end

    // DEPTH=3 latency and taps: entries alu=1,2,3 with rd=11,12,13
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      if (e <= 3) drive(1'b1, 2'b10, 5'(10 + e), 32'(e), 32'h0);
      else        drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
      step();
      chk($sformatf("d3_out_e%0d", e), a3, (e >= 3 && e <= 5) ? 32'(e - 2) : 32'd0);
      chk($sformatf("d3_valid_e%0d", e), {31'd0, v3}, (e >= 3 && e <= 5) ? 32'd1 : 32'd0);
      if (e == 3) begin
        chk("d3_fwd_rd0", {27'd0, frd3[4:0]},   32'd13);
        chk("d3_fwd_rd1", {27'd0, frd3[9:5]},   32'd12);
        chk("d3_fwd_rd2", {27'd0, frd3[14:10]}, 32'd11);
        chk("d3_fwd_data0", fd3[31:0],  32'd3);
        chk("d3_fwd_data1", fd3[63:32], 32'd2);
        chk("d3_fwd_data2", fd3[95:64], 32'd1);
        chk("d3_fwd_we", {29'd0, fwe3}, 32'd7);
      end
    end

    // Stall on DEPTH=2: A in stage 1, B in stage 0, hold 3 cycles
    do_reset();
    drive(1'b1, 2'b10, 5'd2, 32'hA, 32'h0); step();
    drive(1'b1, 2'b10, 5'd3, 32'hB, 32'h0); step();
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall_out_c%0d", c), a2, 32'hA);
      chk($sformatf("stall_s0_c%0d", c), fd2[31:0], 32'hB);
    end
    stall = 1'b0;
    step();
    chk("stall_release", a2, 32'hB);
    chk("stall_release_rd", {27'd0, r2}, 32'd3);

    // Flush with stall on DEPTH=2: Y in stage 1, X in stage 0
    do_reset();
    drive(1'b1, 2'b10, 5'd4, 32'h5959, 32'h0); step();   // Y
    drive(1'b1, 2'b10, 5'd5, 32'h5858, 32'h0); step();   // X
    drive(1'b1, 2'b10, 5'd6, 32'h7777, 32'h0);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_s0_we", {30'd0, fwe2}, 32'd2);
    chk("flush_s0_data", fd2[31:0], 32'd0);
    chk("flush_s1_hold", a2, 32'h5959);
    chk("flush_s1_valid", {31'd0, v2}, 32'd1);
    chk("flush_d1_valid", {31'd0, v1}, 32'd0);
    chk("flush_d1_we", {31'd0, we1}, 32'd0);
    stall = 1'b0;
    step();
    chk("flush_shift_valid", {31'd0, v2}, 32'd0);
    flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);

    // Bubble counter: 10 idle cycles, then run to saturation
    do_reset();
    for (int c = 0; c < 10; c++) step();
    chk("bubble_10", {16'd0, bc1}, 32'd10);
    for (int c = 10; c < 65534; c++) step();
    chk("bubble_fffe", {16'd0, bc1}, 32'hFFFE);
    for (int c = 0; c < 5; c++) step();
    chk("bubble_sat", {16'd0, bc1}, 32'hFFFF);

    // Mid-stream reset clears entries and counter
    drive(1'b1, 2'b11, 5'd9, 32'h1111, 32'h2222);
    step();
    chk("pre_rst_valid", {31'd0, v1}, 32'd1);
    chk("pre_rst_bubble", {16'd0, bc1}, 32'hFFFF);
    rst = 1'b1;
    step();
    chk("mid_rst_bubble", {16'd0, bc1}, 32'd0);
    chk("mid_rst_valid", {31'd0, v1}, 32'd0);
    chk("mid_rst_we", {31'd0, we1}, 32'd0);
    chk("mid_rst_wbdata", wbd1, 32'd0);
    chk("mid_rst_rd", {27'd0, r1}, 32'd0);
    chk("mid_rst_d3_fwd_we", {29'd0, fwe3}, 32'd0);
    chk("mid_rst_d3_fwd_data", fd3[31:0], 32'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB pipeline register, successor to the fixed single-stage MEM/WB latch.
- Adds a valid bit, stall (hold), flush (bubble injection), and configurable depth DEPTH.
- Suppresses writes to the zero register, selects write-back data, exposes per-stage forwarding taps, and keeps a saturating bubble counter.
- Sits between the data-memory stage and the register file; the hazard unit drives stall/flush and reads the forwarding taps.

Parameters:
DATA_W, 32, width of ALU result and memory read data
REG_W, 5, width of destination register index
DEPTH, 1, number of register stages (legal 1..4)
ZERO_REG_SUPPRESS, 1, when 1, reg_write is forced 0 for rd == 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold all stages
flush  input  1  inject bubble into stage 0
valid_in  input  1  incoming instruction valid
wb  input  2  control: bit1 = reg_write, bit0 = mem_to_reg
alu_data  input  DATA_W  ALU result from MEM stage
mem_data  input  DATA_W  memory read data
rd  input  REG_W  destination register
valid_out  output  1  last-stage valid
reg_write  output  1  last-stage qualified register write enable
mem_to_reg  output  1  last-stage data select
alu_data_out  output  DATA_W  last-stage ALU data
mem_data_out  output  DATA_W  last-stage memory data
rd_out  output  REG_W  last-stage destination
wb_data  output  DATA_W  mem_to_reg ? mem_data_out : alu_data_out (combinational)
fwd_we  output  DEPTH  per-stage qualified reg_write, bit k = stage k
fwd_rd  output  DEPTH*REG_W  per-stage rd, slice k = stage k
fwd_data  output  DEPTH*DATA_W  per-stage selected write data, slice k = stage k
bubble_cnt  output  16  saturating count of cycles with valid_out == 0

Behaviour:
- Reset (rst = 1 at a rising edge):
  - All stage fields (valid, reg_write, mem_to_reg, alu, mem, rd) clear to 0.
  - bubble_cnt clears to 0.
  - Reset overrides stall and flush.
  - Asserting reset mid-stream discards all in-flight entries.
- Qualification at stage-0 entry:
  - q_we = wb[1] & valid_in & ~(ZERO_REG_SUPPRESS & (rd == 0)).
  - q_m2r = wb[0] & valid_in.
  - The raw wb[1] is never stored.
- Normal advance (stall = 0, flush = 0):
  - Stage 0 loads {valid_in, q_we, q_m2r, alu_data, mem_data, rd}.
  - Stage k loads stage k-1 for k = 1..DEPTH-1.
  - Latency: input to outputs is exactly DEPTH rising edges.
- Stall = 1, flush = 0: every stage holds its contents; bubble_cnt still updates.
- Flush = 1, regardless of stall:
  - Stage 0 loads a bubble: all fields 0.
  - Stages 1..DEPTH-1 follow the stall input: hold if stall = 1, shift if stall = 0.
- Invalid entries (valid_in = 0) propagate with reg_write = 0 and mem_to_reg = 0; data fields are captured as presented.
- Outputs:
  - reg_write, mem_to_reg, rd_out, alu_data_out, mem_data_out and valid_out come from stage DEPTH-1.
  - wb_data uses the same select as fwd_data slice DEPTH-1.
- Forwarding taps:
  - fwd_data[k] = stage k mem_to_reg ? stage k mem : stage k alu.
  - fwd_we[k] = stage k reg_write.
  - All taps are combinational from registers; no input-to-output combinational path exists.
- bubble_cnt:
  - On each non-reset edge, increments by 1 if the current valid_out == 0.
  - Saturates at 0xFFFF and never wraps.
- DEPTH outside 1..4 is a compile-time error (elaboration check).

Test Plan:
1. DEPTH=1: reset, then valid_in=1, wb=2'b11, rd=7, mem_data=0xDEADBEEF, alu_data=0x1234 → after 1 edge: valid_out=1, reg_write=1, mem_to_reg=1, rd_out=7, wb_data=0xDEADBEEF. With wb=2'b10 instead → wb_data=0x1234.
2. Zero-register suppression: rd=0, wb=2'b10, valid_in=1 → reg_write=0, fwd_we[0]=0. Repeat with ZERO_REG_SUPPRESS=0 → reg_write=1.
3. DEPTH=3: inject a tagged sequence alu_data=1,2,3 on consecutive cycles → alu_data_out is 1,2,3 on edges 3,4,5. fwd_rd/fwd_data slices show each entry in stages 0..2 on the expected cycles.
4. Stall with DEPTH=2, data=0xA then 0xB: assert stall for 3 cycles with 0xA in stage 1 and 0xB in stage 0 → outputs frozen at 0xA for 3 cycles. After release, 0xB appears on the next edge.
5. Flush with stall=1 and DEPTH=2 holding entries X (stage 0) and Y (stage 1) → stage 0 becomes a bubble (fwd_we[0]=0, valid 0), stage 1 still holds Y. Flush alone with DEPTH=1 → valid_out=0 and reg_write=0 on the next edge.
6. bubble_cnt:
   - After reset, hold valid_in=0 for 10 cycles → bubble_cnt=10.
   - Preload near saturation (force 0xFFFE) and run 5 idle cycles → bubble_cnt=0xFFFF.
   - Assert rst mid-operation → bubble_cnt=0 and all outputs 0 on the next edge.
